// File: rtl/light_package.sv
// Shared types for the traffic light controller and its preemption front end.
package light_package;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

  // Controller phases that can be seized by an emergency vehicle
  typedef enum logic [2:0] {
    PH_ES_WS = 3'd0,
    PH_EL_ES = 3'd1,
    PH_WL_WS = 3'd2,
    PH_WL_EL = 3'd3,
    PH_NS    = 3'd4
  } tlc_phase_t;

  typedef enum logic [1:0] {
    IDLE,
    SEIZE,
    HOLD,
    EXIT
  } psched_state_t;

  // Movement bit positions in every 5-bit movement vector
  localparam int NUM_MOVES = 5;
  localparam int MV_ES = 0;
  localparam int MV_WS = 1;
  localparam int MV_EL = 2;
  localparam int MV_WL = 3;
  localparam int MV_NS = 4;

  // Movements that make up a phase
  function automatic logic [NUM_MOVES-1:0] phase_mask(tlc_phase_t ph);
    logic [NUM_MOVES-1:0] m;
    m = '0;
    case (ph)
      PH_ES_WS: begin m[MV_ES] = 1'b1; m[MV_WS] = 1'b1; end
      PH_EL_ES: begin m[MV_EL] = 1'b1; m[MV_ES] = 1'b1; end
      PH_WL_WS: begin m[MV_WL] = 1'b1; m[MV_WS] = 1'b1; end
      PH_WL_EL: begin m[MV_WL] = 1'b1; m[MV_EL] = 1'b1; end
      PH_NS:    m[MV_NS] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlc_preempt_scheduler_if.sv
// Sensor/light/preemption bundle between the intersection side and the scheduler.
interface tlc_preempt_scheduler_if;
  import light_package::*;

  logic  e_str_req, w_str_req, e_left_req, w_left_req, ns_req;
  colors e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
  logic  preempt_req;
  logic  [2:0] preempt_dir;
  logic  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic  preempt_active, preempt_done, preempt_fault;

  modport master (
    output e_str_req, w_str_req, e_left_req, w_left_req, ns_req,
    output e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    output preempt_req, preempt_dir,
    input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    input  preempt_active, preempt_done, preempt_fault
  );

  modport slave (
    input  e_str_req, w_str_req, e_left_req, w_left_req, ns_req,
    input  e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    input  preempt_req, preempt_dir,
    output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    output preempt_active, preempt_done, preempt_fault
  );

endinterface

// File: rtl/tlc_call_memory.sv
// Per-movement call latches: a detector pulse is remembered until the
// movement has been served (its light seen green with no new request).
module tlc_call_memory
  import light_package::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_MOVES-1:0] req,
  input  logic [NUM_MOVES-1:0] is_green,
  output logic [NUM_MOVES-1:0] call
);

  // Set beats clear, so a request arriving while green is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) call <= '0;
    else        call <= req | (call & ~is_green);
  end

endmodule

// File: rtl/tlc_preempt_scheduler.sv
// Front end for traffic_light_controller: holds vehicle calls and, on an
// emergency request, forces one phase to green, holds it, then hands back.
module tlc_preempt_scheduler
  import light_package::*;
#(
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic                    clk,
  input logic                    reset,
  tlc_preempt_scheduler_if.slave bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

  psched_state_t        state;
  tlc_phase_t           dir_q;
  logic                 armed;
  logic [CW-1:0]        cnt, cnt_inc;
  logic [NUM_MOVES-1:0] req, is_green, call, phase_bits, sensors;
  logic                 active_q, done_q, fault_q;

  assign req = {bus.ns_req, bus.w_left_req, bus.e_left_req, bus.w_str_req, bus.e_str_req};
  assign is_green = {bus.ns_light == green, bus.w_left_light == green,
                     bus.e_left_light == green, bus.w_str_light == green,
                     bus.e_str_light == green};
  assign phase_bits = phase_mask(dir_q);
  assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

  tlc_call_memory u_calls (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .is_green (is_green),
    .call     (call)
  );

  // Preemption FSM; sensor mux and status pulses are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      armed    <= 1'b1;
      dir_q    <= PH_ES_WS;
      cnt      <= '0;
      sensors  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      // Re-arm only once the request line has been seen low
      if (!bus.preempt_req) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.preempt_req && armed && bus.preempt_dir <= 3'd4) begin
            state    <= SEIZE;
            dir_q    <= tlc_phase_t'(bus.preempt_dir);
            cnt      <= '0;
            armed    <= 1'b0;
            active_q <= 1'b1;
            sensors  <= phase_mask(tlc_phase_t'(bus.preempt_dir));
          end else begin
            if (bus.preempt_req && armed) begin
              fault_q <= 1'b1;
              armed   <= 1'b0;
            end
            sensors <= call | req;
          end
        end
        SEIZE: begin
          if ((is_green & phase_bits) == phase_bits) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state    <= EXIT;
            fault_q  <= 1'b1;
            active_q <= 1'b0;
            sensors  <= call | req;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state    <= EXIT;
            done_q   <= 1'b1;
            active_q <= 1'b0;
            sensors  <= call | req;
          end else begin
            cnt <= cnt_inc;
          end
        end
        EXIT: begin
          state   <= IDLE;
          sensors <= call | req;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.e_str_sensor   = sensors[MV_ES];
  assign bus.w_str_sensor   = sensors[MV_WS];
  assign bus.e_left_sensor  = sensors[MV_EL];
  assign bus.w_left_sensor  = sensors[MV_WL];
  assign bus.ns_sensor      = sensors[MV_NS];
  assign bus.preempt_active = active_q;
  assign bus.preempt_done   = done_q;
  assign bus.preempt_fault  = fault_q;

endmodule
